// File: rtl/alu_reservation_station_if.sv
// ---------------------------------------------------------------------------
// alu_reservation_station_if
// Groups the ALU reservation station's issue, CDB snoop and ALU dispatch
// signals.
//   master : the surrounding pipeline. It drives issue/CDB/aluReady and
//            observes issueReady plus the dispatch outputs.
//   slave  : the reservation station itself.
// Signals:
//   issueValid/issueReady            issue handshake
//   issueOp/issueDest                opcode and destination tag
//   issueA*/issueB*                  operand value-or-tag, per operand
//   cdbValid/cdbTag/cdbData          result broadcast snooped for wakeup
//   aluValid/aluReady                dispatch handshake
//   aluOp/aluA/aluB/aluDest          dispatched instruction
// ---------------------------------------------------------------------------
interface alu_reservation_station_if #(
  parameter int tagWidth  = 4,
  parameter int dataWidth = 32,
  parameter int opWidth   = 5
);
  logic                 issueValid;
  logic                 issueReady;
  logic [opWidth-1:0]   issueOp;
  logic [tagWidth-1:0]  issueDest;
  logic                 issueAValid;
  logic [dataWidth-1:0] issueAData;
  logic [tagWidth-1:0]  issueATag;
  logic                 issueBValid;
  logic [dataWidth-1:0] issueBData;
  logic [tagWidth-1:0]  issueBTag;
  logic                 cdbValid;
  logic [tagWidth-1:0]  cdbTag;
  logic [dataWidth-1:0] cdbData;
  logic                 aluValid;
  logic                 aluReady;
  logic [opWidth-1:0]   aluOp;
  logic [dataWidth-1:0] aluA;
  logic [dataWidth-1:0] aluB;
  logic [tagWidth-1:0]  aluDest;

  modport master (
    output issueValid, issueOp, issueDest,
    output issueAValid, issueAData, issueATag,
    output issueBValid, issueBData, issueBTag,
    output cdbValid, cdbTag, cdbData, aluReady,
    input  issueReady, aluValid, aluOp, aluA, aluB, aluDest
  );

  modport slave (
    input  issueValid, issueOp, issueDest,
    input  issueAValid, issueAData, issueATag,
    input  issueBValid, issueBData, issueBTag,
    input  cdbValid, cdbTag, cdbData, aluReady,
    output issueReady, aluValid, aluOp, aluA, aluB, aluDest
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ---------------------------------------------------------------------------
// alu_reservation_station
// Holds issued ALU instructions until both source operands are available. It
// snoops the CDB to wake operands that are still waiting. It then dispatches
// the lowest-index ready entry through a registered output stage.
// Ports:
//   clk   clock; all state updates happen on the rising edge
//   rst   synchronous active-high reset; it wins over every same-cycle event
//   bus   alu_reservation_station_if.slave (issue, CDB, dispatch signals)
// ---------------------------------------------------------------------------
module alu_reservation_station #(
  parameter int RS_SIZE   = 4,
  parameter int tagWidth  = 4,
  parameter int dataWidth = 32,
  parameter int opWidth   = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  alu_reservation_station_if.slave    bus
);

  localparam int IDX_W = $clog2(RS_SIZE);

  // Entry storage. Only busy/av/bv need a reset, because the payload fields
  // are never observed while the entry is free.
  logic [RS_SIZE-1:0]   busy_r;
  logic [RS_SIZE-1:0]   av_r;
  logic [RS_SIZE-1:0]   bv_r;
  logic [opWidth-1:0]   op_r   [RS_SIZE];
  logic [tagWidth-1:0]  dest_r [RS_SIZE];
  logic [dataWidth-1:0] ad_r   [RS_SIZE];
  logic [tagWidth-1:0]  at_r   [RS_SIZE];
  logic [dataWidth-1:0] bd_r   [RS_SIZE];
  logic [tagWidth-1:0]  bt_r   [RS_SIZE];

  // Output stage
  logic                 alu_valid_r;
  logic [opWidth-1:0]   alu_op_r;
  logic [dataWidth-1:0] alu_a_r;
  logic [dataWidth-1:0] alu_b_r;
  logic [tagWidth-1:0]  alu_dest_r;

  logic [RS_SIZE-1:0]   ready_s;
  logic [IDX_W-1:0]     free_idx_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic                 any_free_s;
  logic                 any_ready_s;
  logic                 out_free_s;
  logic                 do_issue_s;
  logic                 do_dispatch_s;
  logic                 fwd_a_s;
  logic                 fwd_b_s;

  // Lowest-index free/ready search. The loop runs downward, so the last
  // assignment it makes is the lowest index.
  always_comb begin
    ready_s     = busy_r & av_r & bv_r;
    free_idx_s  = '0;
    sel_idx_s   = '0;
    any_free_s  = ~(&busy_r);
    any_ready_s = |ready_s;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      free_idx_s = (!busy_r[i]) ? IDX_W'(i) : free_idx_s;
      sel_idx_s  = ready_s[i]   ? IDX_W'(i) : sel_idx_s;
    end
  end

  // Handshake decisions. These use start-of-cycle state only, so a slot
  // freed by this cycle's dispatch does not raise issueReady until the
  // next cycle.
  always_comb begin
    out_free_s    = (!alu_valid_r) || bus.aluReady;
    do_issue_s    = bus.issueValid && any_free_s;
    do_dispatch_s = out_free_s && any_ready_s;
    fwd_a_s       = (!bus.issueAValid) && bus.cdbValid && (bus.issueATag == bus.cdbTag);
    fwd_b_s       = (!bus.issueBValid) && bus.cdbValid && (bus.issueBTag == bus.cdbTag);
  end

  // Entry state and the registered dispatch stage
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r      <= '0;
      av_r        <= '0;
      bv_r        <= '0;
      alu_valid_r <= 1'b0;
      alu_op_r    <= '0;
      alu_a_r     <= '0;
      alu_b_r     <= '0;
      alu_dest_r  <= '0;
    end else begin
      // Wakeup: a single broadcast can wake every matching waiting operand
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_r[i] && bus.cdbValid) begin
          if (!av_r[i] && (at_r[i] == bus.cdbTag)) begin
            av_r[i] <= 1'b1;
            ad_r[i] <= bus.cdbData;
          end
          if (!bv_r[i] && (bt_r[i] == bus.cdbTag)) begin
            bv_r[i] <= 1'b1;
            bd_r[i] <= bus.cdbData;
          end
        end
      end

      if (do_dispatch_s) begin
        alu_valid_r       <= 1'b1;
        alu_op_r          <= op_r[sel_idx_s];
        alu_a_r           <= ad_r[sel_idx_s];
        alu_b_r           <= bd_r[sel_idx_s];
        alu_dest_r        <= dest_r[sel_idx_s];
        busy_r[sel_idx_s] <= 1'b0;
      end else if (out_free_s) begin
        alu_valid_r <= 1'b0;
      end

      // The issue target is a free slot. It can never be the dispatched
      // slot or a slot being woken, so these writes do not collide.
      if (do_issue_s) begin
        busy_r[free_idx_s] <= 1'b1;
        op_r[free_idx_s]   <= bus.issueOp;
        dest_r[free_idx_s] <= bus.issueDest;
        av_r[free_idx_s]   <= bus.issueAValid || fwd_a_s;
        ad_r[free_idx_s]   <= fwd_a_s ? bus.cdbData : bus.issueAData;
        at_r[free_idx_s]   <= bus.issueATag;
        bv_r[free_idx_s]   <= bus.issueBValid || fwd_b_s;
        bd_r[free_idx_s]   <= fwd_b_s ? bus.cdbData : bus.issueBData;
        bt_r[free_idx_s]   <= bus.issueBTag;
      end
    end
  end

  assign bus.issueReady = any_free_s;
  assign bus.aluValid   = alu_valid_r;
  assign bus.aluOp      = alu_op_r;
  assign bus.aluA       = alu_a_r;
  assign bus.aluB       = alu_b_r;
  assign bus.aluDest    = alu_dest_r;

endmodule

// File: tb/tb_alu_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_alu_reservation_station
// Self-checking bench for alu_reservation_station. It runs directed
// scenarios, then randomized traffic. Every cycle it compares against a
// slot-list reference model of the station.
// ---------------------------------------------------------------------------
module tb_alu_reservation_station;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_reservation_station_if #(.tagWidth(4), .dataWidth(32), .opWidth(5)) bus ();

  alu_reservation_station #(
    .RS_SIZE(4), .tagWidth(4), .dataWidth(32), .opWidth(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: a list of waiting instructions plus the output stage
  typedef struct {
    bit          busy;
    logic [4:0]  op;
    logic [3:0]  dest;
    bit          av;
    logic [31:0] ad;
    logic [3:0]  at;
    bit          bv;
    logic [31:0] bd;
    logic [3:0]  bt;
  } ent_t;

  ent_t        m [4];
  bit          m_valid = 1'b0;
  logic [4:0]  m_op    = '0;
  logic [31:0] m_a     = '0;
  logic [31:0] m_b     = '0;
  logic [3:0]  m_dest  = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_has_free();
    for (int i = 0; i < 4; i++) if (!m[i].busy) return 1'b1;
    return 1'b0;
  endfunction

  // One clock edge of the station, derived from the behavioural rules
  task automatic model_step();
    ent_t nxt [4];
    int   slot;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m[i].busy = 1'b0; m[i].av = 1'b0; m[i].bv = 1'b0;
      end
      m_valid = 1'b0; m_op = '0; m_a = '0; m_b = '0; m_dest = '0;
      return;
    end
    nxt = m;
    if (!m_valid || bus.aluReady) begin
      slot = -1;
      for (int i = 0; i < 4; i++)
        if (slot < 0 && m[i].busy && m[i].av && m[i].bv) slot = i;
      if (slot >= 0) begin
        m_valid = 1'b1;
        m_op = m[slot].op; m_a = m[slot].ad; m_b = m[slot].bd; m_dest = m[slot].dest;
        nxt[slot].busy = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (bus.cdbValid) begin
      for (int i = 0; i < 4; i++) begin
        if (m[i].busy && !m[i].av && m[i].at == bus.cdbTag) begin
          nxt[i].av = 1'b1; nxt[i].ad = bus.cdbData;
        end
        if (m[i].busy && !m[i].bv && m[i].bt == bus.cdbTag) begin
          nxt[i].bv = 1'b1; nxt[i].bd = bus.cdbData;
        end
      end
    end
    if (bus.issueValid) begin
      slot = -1;
      for (int i = 0; i < 4; i++) if (slot < 0 && !m[i].busy) slot = i;
      if (slot >= 0) begin
        nxt[slot].busy = 1'b1;
        nxt[slot].op   = bus.issueOp;
        nxt[slot].dest = bus.issueDest;
        nxt[slot].at   = bus.issueATag;
        nxt[slot].bt   = bus.issueBTag;
        nxt[slot].av   = bus.issueAValid;
        nxt[slot].ad   = bus.issueAData;
        nxt[slot].bv   = bus.issueBValid;
        nxt[slot].bd   = bus.issueBData;
        if (!bus.issueAValid && bus.cdbValid && bus.issueATag == bus.cdbTag) begin
          nxt[slot].av = 1'b1; nxt[slot].ad = bus.cdbData;
        end
        if (!bus.issueBValid && bus.cdbValid && bus.issueBTag == bus.cdbTag) begin
          nxt[slot].bv = 1'b1; nxt[slot].bd = bus.cdbData;
        end
      end
    end
    m = nxt;
  endtask

  // Advance one clock, then compare every output on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("issueReady", bus.issueReady, m_has_free());
    check_eq("aluValid",   bus.aluValid,   m_valid);
    check_eq("aluOp",      bus.aluOp,      m_op);
    check_eq("aluA",       bus.aluA,       m_a);
    check_eq("aluB",       bus.aluB,       m_b);
    check_eq("aluDest",    bus.aluDest,    m_dest);
  endtask

  task automatic set_idle(input bit ar);
    bus.issueValid = 1'b0; bus.issueOp = '0; bus.issueDest = '0;
    bus.issueAValid = 1'b0; bus.issueAData = '0; bus.issueATag = '0;
    bus.issueBValid = 1'b0; bus.issueBData = '0; bus.issueBTag = '0;
    bus.cdbValid = 1'b0; bus.cdbTag = '0; bus.cdbData = '0;
    bus.aluReady = ar;
  endtask

  task automatic set_issue(input logic [4:0] op, input logic [3:0] dest,
                           input bit av, input logic [31:0] ad, input logic [3:0] at,
                           input bit bv, input logic [31:0] bd, input logic [3:0] bt);
    bus.issueValid = 1'b1; bus.issueOp = op; bus.issueDest = dest;
    bus.issueAValid = av; bus.issueAData = ad; bus.issueATag = at;
    bus.issueBValid = bv; bus.issueBData = bd; bus.issueBTag = bt;
  endtask

  task automatic set_cdb(input logic [3:0] tag, input logic [31:0] data);
    bus.cdbValid = 1'b1; bus.cdbTag = tag; bus.cdbData = data;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m[i] = '{default: '0};
    set_idle(1'b1);
    rst = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset_issueReady", bus.issueReady, 1);
    check_eq("reset_aluValid", bus.aluValid, 0);

    // Both operands ready: the instruction shows up two edges after issue
    set_idle(1'b1); set_issue(5, 3, 1, 7, 0, 1, 9, 0); tick();
    check_eq("t2_not_yet", bus.aluValid, 0);
    set_idle(1'b1); tick();
    check_eq("t2_valid", bus.aluValid, 1);
    check_eq("t2_op", bus.aluOp, 5);
    check_eq("t2_a", bus.aluA, 7);
    check_eq("t2_b", bus.aluB, 9);
    check_eq("t2_dest", bus.aluDest, 3);

    // Wakeup through the CDB after idle cycles
    set_idle(1'b1); set_issue(6, 4, 0, 0, 2, 1, 1, 0); tick();
    set_idle(1'b1); repeat (3) tick();
    check_eq("t3_waiting", bus.aluValid, 0);
    set_cdb(2, 32'h10); tick();
    check_eq("t3_wake_edge", bus.aluValid, 0);
    set_idle(1'b1); tick();
    check_eq("t3_valid", bus.aluValid, 1);
    check_eq("t3_a", bus.aluA, 32'h10);
    check_eq("t3_dest", bus.aluDest, 4);

    // Forwarding from a CDB broadcast in the issue cycle
    set_idle(1'b1); set_issue(7, 7, 0, 0, 6, 1, 2, 0); set_cdb(6, 32'hAB); tick();
    set_idle(1'b1); tick();
    check_eq("t4_valid", bus.aluValid, 1);
    check_eq("t4_a", bus.aluA, 32'hAB);
    check_eq("t4_dest", bus.aluDest, 7);

    // Fill the station behind a stalled output, drop a 5th issue, then drain
    for (int k = 0; k < 4; k++) begin
      set_idle(1'b0); set_issue(5'(k + 1), 4'(k), 1, 32'(100 + k), 0, 1, 32'(200 + k), 0);
      tick();
    end
    check_eq("t5_full", bus.issueReady, 0);
    set_idle(1'b0); set_issue(9, 9, 1, 999, 0, 1, 999, 0); tick();
    check_eq("t5_drop_full", bus.issueReady, 0);
    set_idle(1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("t5_stall_dest", bus.aluDest, 7);
      check_eq("t5_stall_a", bus.aluA, 32'hAB);
    end
    set_idle(1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("t5_order_dest", bus.aluDest, 4'(k));
      check_eq("t5_order_a", bus.aluA, 32'(100 + k));
    end
    tick();
    check_eq("t5_drained", bus.aluValid, 0);

    // One broadcast wakes entries 1 and 3; the lower index goes first
    set_idle(1'b1); set_issue(1, 10, 0, 0, 12, 1, 5, 0); tick();
    set_idle(1'b1); set_issue(2, 11, 0, 0, 4, 1, 6, 0); tick();
    set_idle(1'b1); set_issue(3, 12, 1, 7, 0, 0, 0, 13); tick();
    set_idle(1'b1); set_issue(4, 13, 1, 8, 0, 0, 0, 4); tick();
    set_idle(1'b1); set_cdb(4, 32'h44); tick();
    set_idle(1'b1); tick();
    check_eq("t6_first", bus.aluDest, 11);
    check_eq("t6_first_a", bus.aluA, 32'h44);
    tick();
    check_eq("t6_second", bus.aluDest, 13);
    check_eq("t6_second_b", bus.aluB, 32'h44);
    set_idle(1'b1); set_cdb(12, 32'h12); tick();
    set_idle(1'b1); set_cdb(13, 32'h13); tick();
    set_idle(1'b1); repeat (3) tick();

    // Reset in the middle of traffic with three waiting entries
    for (int k = 0; k < 3; k++) begin
      set_idle(1'b1); set_issue(5'(20 + k), 4'(k), 0, 0, 15, 1, 1, 0); tick();
    end
    set_idle(1'b1); rst = 1'b1; tick(); rst = 1'b0;
    check_eq("t1_issueReady", bus.issueReady, 1);
    check_eq("t1_aluValid", bus.aluValid, 0);
    check_eq("t1_aluOp", bus.aluOp, 0);
    check_eq("t1_aluA", bus.aluA, 0);
    check_eq("t1_aluB", bus.aluB, 0);
    check_eq("t1_aluDest", bus.aluDest, 0);
    set_idle(1'b1); set_cdb(15, 32'h55); tick();
    set_idle(1'b1); tick(); tick();
    check_eq("t1_no_old_dispatch", bus.aluValid, 0);

    // Randomized traffic checked against the model on every cycle
    for (int c = 0; c < 800; c++) begin
      set_idle($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) < 6)
        set_issue(5'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), $urandom,
                  4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                  4'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1)
        set_cdb(4'($urandom_range(0, 7)), $urandom);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
